// File: rtl/fpu_ctrl_pkg.sv
// Shared definitions for the FPU issue controller: op code fields, flag bit
// positions and the in-flight tracker entry.
package fpu_ctrl_pkg;

  // Low two bits of the op code select the datapath; 00 selects nothing.
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_FMA  = 2'b11;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Tracker field widths; the top's TAGW and requester index width follow these.
  localparam int TRK_TAGW = 4;
  localparam int TRK_SRCW = 1;

  typedef struct packed {
    logic                valid;
    logic [TRK_TAGW-1:0] tag;
    logic [TRK_SRCW-1:0] src;
    logic                illegal;
  } trk_entry_t;

  function automatic logic is_illegal(input logic [1:0] unit_sel);
    return unit_sel == OP_NONE;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer and wraps; the pointer
// moves just past each winner and holds when nothing is granted.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx
);

  logic [PW-1:0] ptr;
  logic          found;
  int            j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && valid[j]) begin
        found     = 1'b1;
        grant_idx = PW'(j);
      end
    end
    if (!enable) found = 1'b0;
    if (found) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue controller for the FP unpack/FMA pipeline: round-robin issue, fixed-latency
// tracking and a credit-protected result buffer drained by writeback.
module fpu_issue_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int FW   = 23,
  parameter int EW   = 8,
  parameter int LAT  = 4,
  parameter int TAGW = TRK_TAGW,
  parameter int RBUF = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   flush,
  input  logic [NREQ-1:0]                        req_valid,
  output logic [NREQ-1:0]                        req_ready,
  input  logic [NREQ*4-1:0]                      req_op,
  input  logic [NREQ*(EW+FW+1)-1:0]              req_a,
  input  logic [NREQ*(EW+FW+1)-1:0]              req_b,
  input  logic [NREQ*(EW+FW+1)-1:0]              req_c,
  input  logic [NREQ*TAGW-1:0]                   req_tag,
  output logic                                   fpu_valid,
  output logic [3:0]                             fpu_op,
  output logic [EW+FW:0]                         fpu_opA,
  output logic [EW+FW:0]                         fpu_opB,
  output logic [EW+FW:0]                         fpu_opC,
  input  logic [EW+FW:0]                         fpu_result,
  input  logic [4:0]                             fpu_flags,
  output logic                                   wb_valid,
  input  logic                                   wb_ready,
  output logic [EW+FW:0]                         wb_result,
  output logic [4:0]                             wb_flags,
  output logic [TAGW-1:0]                        wb_tag,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] wb_src,
  output logic                                   busy
);

  localparam int DW = EW + FW + 1;
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = $clog2(RBUF);
  localparam int UW = $clog2(RBUF + 1);
  localparam logic [UW-1:0] RBUF_U = UW'(RBUF);
  localparam logic [4:0] FLAGS_INVALID = 5'b1 << FLAG_NV;

  logic [UW-1:0]   used;
  logic            grant_en;
  logic [NREQ-1:0] grant;
  logic [SW-1:0]   grant_idx;
  logic            issue;
  logic [3:0]      sel_op;
  logic [DW-1:0]   sel_a, sel_b, sel_c;
  logic [TAGW-1:0] sel_tag;
  logic [TAGW-1:0] iss_tag;
  logic [SW-1:0]   iss_src;
  trk_entry_t      trk [LAT];
  trk_entry_t      trk_in;
  logic            trk_busy;
  logic [DW-1:0]   buf_result [RBUF];
  logic [4:0]      buf_flags  [RBUF];
  logic [TAGW-1:0] buf_tag    [RBUF];
  logic [SW-1:0]   buf_src    [RBUF];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            empty, full, capture, pop;

  // Reset gates the grant too, so the combinational ready is 0 while held in reset.
  assign grant_en  = rst_n & ~flush & (used < RBUF_U);
  assign req_ready = grant;
  assign issue     = |grant;

  rr_arbiter #(.NREQ(NREQ), .PW(SW)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (grant_en),
    .valid     (req_valid),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_op  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_c   = '0;
    sel_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_op  = req_op[i*4 +: 4];
        sel_a   = req_a[i*DW +: DW];
        sel_b   = req_b[i*DW +: DW];
        sel_c   = req_c[i*DW +: DW];
        sel_tag = req_tag[i*TAGW +: TAGW];
      end
    end
  end

  // Operands hold their last issued value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_valid <= 1'b0;
      fpu_op    <= '0;
      fpu_opA   <= '0;
      fpu_opB   <= '0;
      fpu_opC   <= '0;
      iss_tag   <= '0;
      iss_src   <= '0;
    end else begin
      fpu_valid <= issue;
      if (issue) begin
        fpu_op  <= sel_op;
        fpu_opA <= sel_a;
        fpu_opB <= sel_b;
        fpu_opC <= sel_c;
        iss_tag <= sel_tag;
        iss_src <= grant_idx;
      end
    end
  end

  always_comb begin
    trk_in.valid   = fpu_valid & ~flush;
    trk_in.tag     = iss_tag;
    trk_in.src     = iss_src;
    trk_in.illegal = is_illegal(fpu_op[1:0]);
  end

  // The tail stage lines up with the cycle the pipeline presents this op's result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) trk[k] <= '0;
    end else begin
      trk[0] <= trk_in;
      for (int k = 1; k < LAT; k++) begin
        trk[k] <= trk[k-1];
        if (flush) trk[k].valid <= 1'b0;
      end
    end
  end

  always_comb begin
    trk_busy = 1'b0;
    for (int k = 0; k < LAT; k++) trk_busy = trk_busy | trk[k].valid;
  end

  assign capture = trk[LAT-1].valid & ~flush;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop     = ~empty & wb_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (capture) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      buf_result[wr_ptr[AW-1:0]] <= trk[LAT-1].illegal ? '0 : fpu_result;
      buf_flags[wr_ptr[AW-1:0]]  <= trk[LAT-1].illegal ? FLAGS_INVALID : fpu_flags;
      buf_tag[wr_ptr[AW-1:0]]    <= trk[LAT-1].tag;
      buf_src[wr_ptr[AW-1:0]]    <= trk[LAT-1].src;
    end
  end

  // Credits cover everything issued but not yet popped, so the buffer can never overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used <= '0;
    end else if (flush) begin
      used <= '0;
    end else begin
      used <= used + UW'(issue) - UW'(pop);
    end
  end

  assign wb_valid  = ~empty;
  assign wb_result = empty ? '0 : buf_result[rd_ptr[AW-1:0]];
  assign wb_flags  = empty ? '0 : buf_flags[rd_ptr[AW-1:0]];
  assign wb_tag    = empty ? '0 : buf_tag[rd_ptr[AW-1:0]];
  assign wb_src    = empty ? '0 : buf_src[rd_ptr[AW-1:0]];
  assign busy      = trk_busy | ~empty | fpu_valid;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(capture && full && !pop));

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a behavioural fixed-latency FPU model
// and hand-computed expected values.
module tb_fpu_issue_ctrl;
  import fpu_ctrl_pkg::*;

  localparam int NREQ = 2;
  localparam int FW   = 23;
  localparam int EW   = 8;
  localparam int LAT  = 4;
  localparam int TAGW = 4;
  localparam int RBUF = 4;
  localparam int DW   = EW + FW + 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*4-1:0]     req_op;
  logic [NREQ*DW-1:0]    req_a, req_b, req_c;
  logic [NREQ*TAGW-1:0]  req_tag;
  logic                  fpu_valid;
  logic [3:0]            fpu_op;
  logic [DW-1:0]         fpu_opA, fpu_opB, fpu_opC;
  logic [DW-1:0]         fpu_result;
  logic [4:0]            fpu_flags;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [DW-1:0]         wb_result;
  logic [4:0]            wb_flags;
  logic [TAGW-1:0]       wb_tag;
  logic [0:0]            wb_src;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  fpu_issue_ctrl #(
    .NREQ(NREQ), .FW(FW), .EW(EW), .LAT(LAT), .TAGW(TAGW), .RBUF(RBUF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_c      (req_c),
    .req_tag    (req_tag),
    .fpu_valid  (fpu_valid),
    .fpu_op     (fpu_op),
    .fpu_opA    (fpu_opA),
    .fpu_opB    (fpu_opB),
    .fpu_opC    (fpu_opC),
    .fpu_result (fpu_result),
    .fpu_flags  (fpu_flags),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_result  (wb_result),
    .wb_flags   (wb_flags),
    .wb_tag     (wb_tag),
    .wb_src     (wb_src),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Stand-in FPU: 2.0*3.0 gives 6.0, everything else an integer sum; flags by unit.
  function automatic logic [DW-1:0] model_result(input logic [3:0] op, input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b, input logic [DW-1:0] c);
    if (op[1:0] == OP_MUL && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return a + b + c;
  endfunction

  function automatic logic [4:0] model_flags(input logic [3:0] op);
    case (op[1:0])
      OP_MUL:  return 5'b1 << FLAG_NX;
      OP_ADD:  return (5'b1 << FLAG_NX) | (5'b1 << FLAG_UF);
      OP_FMA:  return (5'b1 << FLAG_NX) | (5'b1 << FLAG_OF);
      default: return 5'b1 << FLAG_DZ;
    endcase
  endfunction

  logic [DW-1:0] pipe_res   [LAT];
  logic [4:0]    pipe_flags [LAT];

  initial begin
    for (int k = 0; k < LAT; k++) begin
      pipe_res[k]   = '0;
      pipe_flags[k] = '0;
    end
    fpu_result = '0;
    fpu_flags  = '0;
  end

  // The result leaves the line LAT cycles after fpu_valid and is sampled on the next rising edge.
  always @(negedge clk) begin
    fpu_result = pipe_res[LAT-1];
    fpu_flags  = pipe_flags[LAT-1];
    for (int k = LAT - 1; k > 0; k--) begin
      pipe_res[k]   = pipe_res[k-1];
      pipe_flags[k] = pipe_flags[k-1];
    end
    pipe_res[0]   = fpu_valid ? model_result(fpu_op, fpu_opA, fpu_opB, fpu_opC) : 32'hDEAD_BEEF;
    pipe_flags[0] = fpu_valid ? model_flags(fpu_op) : 5'b11111;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic ready, input logic fl);
    req_valid = valid;
    wb_ready  = ready;
    flush     = fl;
    #1;
  endtask

  task automatic setRequest(input int idx, input logic [3:0] op, input logic [TAGW-1:0] tag,
                            input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    req_op[idx*4 +: 4]        = op;
    req_tag[idx*TAGW +: TAGW] = tag;
    req_a[idx*DW +: DW]       = a;
    req_b[idx*DW +: DW]       = b;
    req_c[idx*DW +: DW]       = c;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drainAll(input string name);
    int n;
    applyStimulus(2'b00, 1'b1, 1'b0);
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    checkOutput(name, busy, 0);
  endtask

  initial begin
    int accepts;
    int wb_seen;
    logic [1:0] burst_rdy [9];
    burst_rdy = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
    req_op = '0; req_a = '0; req_b = '0; req_c = '0; req_tag = '0;
    applyStimulus(2'b11, 1'b0, 1'b0);
    tick(); tick();

    $display("[TB] reset state");
    checkOutput("rst_req_ready", req_ready, 2'b00);
    checkOutput("rst_fpu_valid", fpu_valid, 0);
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fpu_opA", fpu_opA, 0);
    checkOutput("rst_wb_result", wb_result, 0);
    applyStimulus(2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    $display("[TB] single MUL from req0");
    setRequest(0, {2'b00, OP_MUL}, 4'd3, 32'h4000_0000, 32'h4040_0000, 32'h0);
    applyStimulus(2'b01, 1'b0, 1'b0);
    checkOutput("mul_ready", req_ready, 2'b01);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("mul_fpu_valid", fpu_valid, 1);
    checkOutput("mul_fpu_op", fpu_op, 4'b0001);
    checkOutput("mul_opA", fpu_opA, 32'h4000_0000);
    checkOutput("mul_opB", fpu_opB, 32'h4040_0000);
    tick();
    checkOutput("mul_pulse", fpu_valid, 0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("mul_wb_early", wb_valid, 0);
    tick();
    checkOutput("mul_wb_valid", wb_valid, 1);
    checkOutput("mul_wb_result", wb_result, 32'h40C0_0000);
    checkOutput("mul_wb_flags", wb_flags, 5'b00001);
    checkOutput("mul_wb_tag", wb_tag, 4'd3);
    checkOutput("mul_wb_src", wb_src, 0);
    checkOutput("mul_busy", busy, 1);
    applyStimulus(2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("mul_popped", wb_valid, 0);
    checkOutput("mul_idle", busy, 0);

    $display("[TB] illegal op from req1");
    setRequest(1, 4'b0000, 4'd9, 32'h3F80_0000, 32'h3F80_0000, 32'h0);
    applyStimulus(2'b10, 1'b0, 1'b0);
    checkOutput("ill_ready", req_ready, 2'b10);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("ill_fpu_valid", fpu_valid, 1);
    checkOutput("ill_fpu_op", fpu_op, 4'b0000);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("ill_wb_valid", wb_valid, 1);
    checkOutput("ill_wb_result", wb_result, 0);
    checkOutput("ill_wb_flags", wb_flags, 5'b10000);
    checkOutput("ill_wb_tag", wb_tag, 4'd9);
    checkOutput("ill_wb_src", wb_src, 1);
    applyStimulus(2'b00, 1'b1, 1'b0);
    tick();

    $display("[TB] round-robin burst with credit throttling");
    setRequest(0, {2'b00, OP_ADD}, 4'd1, 32'h3F80_0000, 32'h4000_0000, 32'h0);
    setRequest(1, {2'b01, OP_FMA}, 4'd2, 32'h4000_0000, 32'h4000_0000, 32'h3F80_0000);
    applyStimulus(2'b11, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("burst_rdy%0d", i), req_ready, burst_rdy[i]);
      if (i == 6) begin
        checkOutput("burst_wb0_valid", wb_valid, 1);
        checkOutput("burst_wb0_src", wb_src, 0);
        checkOutput("burst_wb0_result", wb_result, 32'h7F80_0000);
        checkOutput("burst_wb0_flags", wb_flags, 5'b00011);
      end
      if (i == 7) begin
        checkOutput("burst_wb1_src", wb_src, 1);
        checkOutput("burst_wb1_tag", wb_tag, 4'd2);
        checkOutput("burst_wb1_result", wb_result, 32'hBF80_0000);
        checkOutput("burst_wb1_flags", wb_flags, 5'b00101);
      end
      tick();
    end
    drainAll("burst_drain");

    $display("[TB] credits with writeback stalled");
    applyStimulus(2'b11, 1'b0, 1'b0);
    accepts = 0;
    for (int i = 0; i < 12; i++) begin
      accepts += $countones(req_ready);
      tick();
    end
    checkOutput("credit_accepts", accepts, 4);
    checkOutput("credit_hold", req_ready, 2'b00);
    checkOutput("credit_buffered", wb_valid, 1);
    applyStimulus(2'b11, 1'b1, 1'b0);
    checkOutput("credit_same_cycle", req_ready, 2'b00);
    tick();
    applyStimulus(2'b11, 1'b0, 1'b0);
    checkOutput("credit_reuse", $countones(req_ready), 1);
    tick();
    checkOutput("credit_after_reuse", req_ready, 2'b00);
    drainAll("credit_drain");

    $display("[TB] flush with work in flight");
    applyStimulus(2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    applyStimulus(2'b00, 1'b0, 1'b0);
    tick(); tick();
    checkOutput("flush_pre_wb", wb_valid, 1);
    checkOutput("flush_pre_busy", busy, 1);
    applyStimulus(2'b01, 1'b0, 1'b1);
    checkOutput("flush_ready", req_ready, 2'b00);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("flush_wb_drop", wb_valid, 0);
    checkOutput("flush_busy", busy, 0);
    wb_seen = 0;
    for (int i = 0; i < 8; i++) begin
      wb_seen += int'(wb_valid);
      tick();
    end
    checkOutput("flush_no_late_wb", wb_seen, 0);
    applyStimulus(2'b01, 1'b0, 1'b0);
    checkOutput("flush_credit_free", req_ready, 2'b01);

    $display("[TB] reset mid-burst");
    applyStimulus(2'b11, 1'b1, 1'b0);
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_fpu_valid", fpu_valid, 0);
    checkOutput("midrst_req_ready", req_ready, 2'b00);
    checkOutput("midrst_wb_valid", wb_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_opA", fpu_opA, 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_first_grant", req_ready, 2'b01);
    tick();
    checkOutput("midrst_issue", fpu_valid, 1);
    checkOutput("midrst_issue_opA", fpu_opA, 32'h3F80_0000);
    drainAll("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
